muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port start, input, 1, request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2, operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have port src_a, input, 32, multiplicand or dividend (rs).
REQ-006 SHALL have port src_b, input, 32, multiplier or divisor (rt).
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking hi/lo update.
REQ-009 SHALL have port hi, output, 32, HI register: product[63:32] or remainder.
REQ-010 SHALL have port lo, output, 32, LO register: product[31:0] or quotient.
REQ-011 SHALL have port div_zero, output, 1, high with done when a divide had src_b==0.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after 32 RUN cycles; DONE->IDLE unconditionally.
REQ-013 SHALL latch op, src_a and src_b on the edge where start is accepted; later input changes have no effect.
REQ-014 SHALL use a 5-bit iteration counter, cleared on accept and incremented each RUN cycle; RUN exits when it reaches 31.
REQ-015 SHALL multiply by iterative shift-add, one multiplier bit per cycle, on 32-bit magnitudes.
REQ-016 SHALL divide by restoring shift-subtract, one quotient bit per cycle, on 32-bit magnitudes.
REQ-017 SHALL, for MULT, negate the 64-bit product when the operand signs differ.
REQ-018 SHALL, for DIV, negate the quotient when signs differ; the remainder takes the dividend's sign.
REQ-019 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give lo=0x80000000 and hi=0x00000000 (wrap, no trap).
REQ-020 SHALL, for start accepted at edge k, hold busy=1 in cycles k+1..k+32 and done=1 in cycle k+33 only.
REQ-021 SHALL update hi/lo on the edge entering DONE; they hold their value until the next completion.
REQ-022 SHALL ignore start while busy=1 or during DONE; no queuing.
REQ-023 SHALL, on a divide with src_b==0, go IDLE->DONE directly (done at k+1), leave hi/lo unchanged, assert div_zero with done.
REQ-024 SHALL drive div_zero=0 whenever done=0.

Reset
REQ-025 SHALL, with rst_n=0 at a clock edge, enter IDLE and clear busy, done, div_zero, hi, lo and the counter to 0.
REQ-026 SHALL, on reset during RUN or DONE, abandon the operation without any hi/lo update; reset has priority over start.

Configuration
REQ-027 SHALL compile the divider datapath (REQ-016, 018, 019, 023) only when MULDIV_DIV_EN is defined.
REQ-028 SHALL, without MULDIV_DIV_EN, treat op[1]=1 as a no-op: go IDLE->DONE, pulse done at k+1, leave hi/lo unchanged, div_zero=0.

Verification
REQ-029 SHALL check MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after the start edge.
REQ-030 SHALL check MULT 0xFFFFFFFD (-3) x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-031 SHALL check DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
REQ-032 SHALL check DIVU 5/0 after a prior result -> done one cycle after start, div_zero=1, hi/lo unchanged.
REQ-033 SHALL check start pulsed at RUN cycle 5 is ignored, and rst_n=0 at RUN cycle 10 -> next cycle busy=0, done=0, hi=lo=0.
REQ-034 SHALL check, with MULDIV_DIV_EN undefined, DIV 8/2 -> done at k+1, hi/lo unchanged, div_zero=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Divider datapath is built only when MULDIV_DIV_EN is defined; otherwise divide ops complete as no-ops.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  low_q, low_d;
    logic          neg_res_q, neg_res_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;

    logic          a_neg, b_neg;
    logic [W-1:0]  a_mag, b_mag;
    logic [W:0]    mul_sum;
    logic [W-1:0]  step_acc, step_low;
    logic [2*W-1:0] prod, prod_s;

    // Operand magnitudes; only signed ops (op[0]) see negative inputs.
    always_comb begin
        a_neg = op[0] & src_a[W-1];
        b_neg = op[0] & src_b[W-1];
        a_mag = a_neg ? (-src_a) : src_a;
        b_mag = b_neg ? (-src_b) : src_b;
    end

    // One shift-add step: {acc,low} holds the partial product, low shifts the multiplier out.
    always_comb begin
        mul_sum = {1'b0, acc_q} + {1'b0, (low_q[0] ? m_q : W'(0))};
        prod    = {mul_sum[W:1], mul_sum[0], low_q[W-1:1]};
        prod_s  = neg_res_q ? (-prod) : prod;
    end

`ifdef MULDIV_DIV_EN
    logic          is_div_q, is_div_d;
    logic          neg_rem_q, neg_rem_d;
    logic [W:0]    div_shift, div_diff;
    logic          div_ok;
    logic [W-1:0]  div_acc, div_low;

    // Restoring division step: acc is the partial remainder, low shifts dividend out and quotient in.
    always_comb begin
        div_shift = {acc_q, low_q[W-1]};
        div_diff  = div_shift - {1'b0, m_q};
        div_ok    = ~div_diff[W];
        div_acc   = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
        div_low   = {low_q[W-2:0], div_ok};
        step_acc  = is_div_q ? div_acc : prod[2*W-1:W];
        step_low  = is_div_q ? div_low : prod[W-1:0];
    end
`else
    always_comb begin
        step_acc = prod[2*W-1:W];
        step_low = prod[W-1:0];
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        acc_d     = acc_q;
        low_d     = low_q;
        neg_res_d = neg_res_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        dz_d      = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(0);
                    acc_d     = W'(0);
                    neg_res_d = op[0] & (src_a[W-1] ^ src_b[W-1]);
                    m_d       = a_mag;
                    low_d     = b_mag;
`ifdef MULDIV_DIV_EN
                    is_div_d  = op[1];
                    neg_rem_d = a_neg;
                    if (op[1]) begin
                        m_d   = b_mag;
                        low_d = a_mag;
                    end
                    // Divide by zero completes immediately, results untouched.
                    if (op[1] && (src_b == W'(0))) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end
`else
                    if (op[1]) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                low_d = step_low;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == '1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hi_d    = prod_s[2*W-1:W];
                    lo_d    = prod_s[W-1:0];
`ifdef MULDIV_DIV_EN
                    if (is_div_q) begin
                        hi_d = neg_rem_q ? (-step_acc) : step_acc;
                        lo_d = neg_res_q ? (-step_low) : step_low;
                    end
`endif
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= CW'(0);
            m_q       <= W'(0);
            acc_q     <= W'(0);
            low_q     <= W'(0);
            neg_res_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= W'(0);
            lo_q      <= W'(0);
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            neg_res_q <= neg_res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
